// File: rtl/regarb_pkg.sv
// regarb_pkg: shared types and constants for the register-file arbiter.
// Optional feature macro used by this slice: REGARB_ROUND_ROBIN_EN.
package regarb_pkg;

  localparam int RF_SEL_W  = 2;
  localparam int RF_DATA_W = 8;

  // Arbiter FSM: free, or locked to one requester.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OWN_A = 2'd1,
    OWN_B = 2'd2
  } state_e;

  // Requester identity as carried in the response pipeline and RR pointer.
  typedef enum logic {
    OWNER_A = 1'b0,
    OWNER_B = 1'b1
  } owner_e;

endpackage

// File: rtl/regarb_pick.sv
// regarb_pick: two-way picker used while the arbiter is IDLE.
// REGARB_ROUND_ROBIN_EN defined: round-robin with a preferred-requester flop.
// REGARB_ROUND_ROBIN_EN undefined: fixed priority, A over B, no flop.
module regarb_pick
  import regarb_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic a_valid_i,
  input  logic b_valid_i,
  input  logic accept_i,        // a transaction was accepted this cycle
  input  logic accept_owner_i,  // which requester it belonged to (OWNER_*)
  output logic pick_b_o         // 1 = B wins the contest, 0 = A (or nobody)
);

`ifdef REGARB_ROUND_ROBIN_EN
  // ptr_q names the requester that wins the next contested cycle.
  logic ptr_q, ptr_d;

  // After any accepted transaction, prefer the requester that was not served.
  always_comb begin
    ptr_d = ptr_q;
    if (accept_i) begin
      ptr_d = ~accept_owner_i;
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Preferred-requester flop, starts out favouring A.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_q <= OWNER_A;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  // Contest resolved by the pointer; otherwise whoever is valid.
  always_comb begin
    pick_b_o = 1'b0;
    if (a_valid_i && b_valid_i) begin
      pick_b_o = (ptr_q == OWNER_B);
    end else begin
      pick_b_o = b_valid_i;
    end
  end
`else
  // Fixed priority needs no history.
  logic unused_s;
  assign unused_s = ^{clk, reset, accept_i, accept_owner_i};

  // B only wins when A is not asking.
  always_comb begin
    pick_b_o = b_valid_i && !a_valid_i;
  end
`endif

endmodule

// File: rtl/reg_file_arbiter.sv
// reg_file_arbiter: shares register-file read port 0 and the write port
// between the core (A) and the debug port (B), with locked sequences and a
// lock watchdog. Optional macro: REGARB_ROUND_ROBIN_EN (round-robin picking).
module reg_file_arbiter
  import regarb_pkg::*;
#(
  parameter int LOCK_MAX = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 a_req_valid,
  input  logic                 a_req_wr,
  input  logic [RF_SEL_W-1:0]  a_req_sel,
  input  logic [RF_DATA_W-1:0] a_req_wdata,
  input  logic                 a_req_lock,
  output logic                 a_req_ready,
  output logic                 a_rsp_valid,
  output logic [RF_DATA_W-1:0] a_rsp_data,
  input  logic                 b_req_valid,
  input  logic                 b_req_wr,
  input  logic [RF_SEL_W-1:0]  b_req_sel,
  input  logic [RF_DATA_W-1:0] b_req_wdata,
  input  logic                 b_req_lock,
  output logic                 b_req_ready,
  output logic                 b_rsp_valid,
  output logic [RF_DATA_W-1:0] b_rsp_data,
  output logic                 rf_rd_en_0,
  output logic [RF_SEL_W-1:0]  rf_rd_sel_0,
  output logic                 rf_wr_en,
  output logic [RF_SEL_W-1:0]  rf_wr_sel,
  output logic [RF_DATA_W-1:0] rf_wr_data,
  input  logic [RF_DATA_W-1:0] rf_rd_data_0,
  output logic                 lock_err
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 lock_err_q, lock_err_d;
  logic                 rsp_pend_q, rsp_pend_d;
  logic                 rsp_owner_q, rsp_owner_d;

  logic                 pick_b_s;
  logic                 a_ready_s, b_ready_s;
  logic                 grant_a_s, grant_b_s, grant_s;
  logic                 g_wr_s, g_lock_s;
  logic [RF_SEL_W-1:0]  g_sel_s;
  logic [RF_DATA_W-1:0] g_wdata_s;

  regarb_pick u_pick (
    .clk            (clk),
    .reset          (reset),
    .a_valid_i      (a_req_valid),
    .b_valid_i      (b_req_valid),
    .accept_i       (grant_s),
    .accept_owner_i (grant_b_s),
    .pick_b_o       (pick_b_s)
  );

  // Ready per requester: picker decides in IDLE, the owner alone while locked.
  always_comb begin
    a_ready_s = 1'b0;
    b_ready_s = 1'b0;
    if (reset) begin
      a_ready_s = 1'b0;
      b_ready_s = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          a_ready_s = a_req_valid && !pick_b_s;
          b_ready_s = b_req_valid && pick_b_s;
        end
        OWN_A:   a_ready_s = a_req_valid;
        OWN_B:   b_ready_s = b_req_valid;
        default: begin
          a_ready_s = 1'b0;
          b_ready_s = 1'b0;
        end
      endcase
    end
  end

  assign a_req_ready = a_ready_s;
  assign b_req_ready = b_ready_s;
  assign grant_a_s   = a_req_valid && a_ready_s;
  assign grant_b_s   = b_req_valid && b_ready_s;
  assign grant_s     = grant_a_s || grant_b_s;

  // Select the fields of whichever requester holds the grant.
  always_comb begin
    if (grant_b_s) begin
      g_wr_s    = b_req_wr;
      g_lock_s  = b_req_lock;
      g_sel_s   = b_req_sel;
      g_wdata_s = b_req_wdata;
    end else begin
      g_wr_s    = a_req_wr;
      g_lock_s  = a_req_lock;
      g_sel_s   = a_req_sel;
      g_wdata_s = a_req_wdata;
    end
  end

  // Drive the register file from the granted transaction; quiet otherwise.
  always_comb begin
    rf_rd_en_0  = 1'b0;
    rf_rd_sel_0 = '0;
    rf_wr_en    = 1'b0;
    rf_wr_sel   = '0;
    rf_wr_data  = '0;
    if (grant_s && !g_wr_s) begin
      rf_rd_en_0  = 1'b1;
      rf_rd_sel_0 = g_sel_s;
    end else if (grant_s && g_wr_s) begin
      rf_wr_en    = 1'b1;
      rf_wr_sel   = g_sel_s;
      rf_wr_data  = g_wdata_s;
    end else begin
      rf_rd_en_0  = 1'b0;
    end
  end

  // Lock entry/exit and watchdog; an owner releasing on time is not an error.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_s && g_lock_s) begin
          state_d = grant_b_s ? OWN_B : OWN_A;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      OWN_A, OWN_B: begin
        if (grant_s && !g_lock_s) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d    = IDLE;
          cnt_d      = '0;
          lock_err_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Remember who owns the read in flight so its data is routed next cycle.
  always_comb begin
    rsp_pend_d  = grant_s && !g_wr_s;
    rsp_owner_d = grant_b_s ? OWNER_B : OWNER_A;
  end

  // State, watchdog counter, error pulse and response pipeline registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      lock_err_q  <= 1'b0;
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= OWNER_A;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      lock_err_q  <= lock_err_d;
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  assign lock_err    = lock_err_q;
  assign a_rsp_valid = rsp_pend_q && (rsp_owner_q == OWNER_A);
  assign b_rsp_valid = rsp_pend_q && (rsp_owner_q == OWNER_B);
  assign a_rsp_data  = a_rsp_valid ? rf_rd_data_0 : '0;
  assign b_rsp_data  = b_rsp_valid ? rf_rd_data_0 : '0;

endmodule

// File: tb/tb_reg_file_arbiter.sv
// tb_reg_file_arbiter: directed table plus randomized traffic against a
// behavioural model; two DUTs (LOCK_MAX 8 and 1) share the same stimulus.
module tb_reg_file_arbiter;

`ifdef REGARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  typedef struct {
    logic [31:0] rst, av, awr, asel, awd, alk, bv, bwr, bsel, bwd, blk;
    logic [31:0] ardy, brdy, arv, ard, brv, brd, wen, wsel, wd, lerr;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       av = 1'b0, awr = 1'b0, alk = 1'b0, bv = 1'b0, bwr = 1'b0, blk = 1'b0;
  logic [1:0] asel = 2'd0, bsel = 2'd0;
  logic [7:0] awd = 8'd0, bwd = 8'd0;

  logic [1:0]       a_rdy, b_rdy, a_rv, b_rv, rden, wen, lerr;
  logic [1:0][1:0]  rsel, wsel;
  logic [1:0][7:0]  a_rd, b_rd, wd, rdd;

  reg_file_arbiter #(.LOCK_MAX(8)) dut0 (
    .clk(clk), .reset(rst),
    .a_req_valid(av), .a_req_wr(awr), .a_req_sel(asel), .a_req_wdata(awd), .a_req_lock(alk),
    .a_req_ready(a_rdy[0]), .a_rsp_valid(a_rv[0]), .a_rsp_data(a_rd[0]),
    .b_req_valid(bv), .b_req_wr(bwr), .b_req_sel(bsel), .b_req_wdata(bwd), .b_req_lock(blk),
    .b_req_ready(b_rdy[0]), .b_rsp_valid(b_rv[0]), .b_rsp_data(b_rd[0]),
    .rf_rd_en_0(rden[0]), .rf_rd_sel_0(rsel[0]), .rf_wr_en(wen[0]), .rf_wr_sel(wsel[0]),
    .rf_wr_data(wd[0]), .rf_rd_data_0(rdd[0]), .lock_err(lerr[0])
  );

  reg_file_arbiter #(.LOCK_MAX(1)) dut1 (
    .clk(clk), .reset(rst),
    .a_req_valid(av), .a_req_wr(awr), .a_req_sel(asel), .a_req_wdata(awd), .a_req_lock(alk),
    .a_req_ready(a_rdy[1]), .a_rsp_valid(a_rv[1]), .a_rsp_data(a_rd[1]),
    .b_req_valid(bv), .b_req_wr(bwr), .b_req_sel(bsel), .b_req_wdata(bwd), .b_req_lock(blk),
    .b_req_ready(b_rdy[1]), .b_rsp_valid(b_rv[1]), .b_rsp_data(b_rd[1]),
    .rf_rd_en_0(rden[1]), .rf_rd_sel_0(rsel[1]), .rf_wr_en(wen[1]), .rf_wr_sel(wsel[1]),
    .rf_wr_data(wd[1]), .rf_rd_data_0(rdd[1]), .lock_err(lerr[1])
  );

  // One 4x8 register file per DUT, driven only by that DUT's rf_* outputs.
  logic [7:0] mem [2][4] = '{default: 8'h00};
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (wen[k]) mem[k][wsel[k]] <= wd[k];
      if (rden[k]) rdd[k] <= mem[k][rsel[k]];
    end
  end

  // Behavioural model: owner -1 = nobody, 0 = A, 1 = B.
  int         lmax   [2] = '{8, 1};
  int         m_own  [2] = '{-1, -1};
  int         m_held [2] = '{0, 0};
  int         m_pref [2] = '{0, 0};
  bit         m_pend [2] = '{1'b0, 1'b0};
  int         m_pown [2] = '{0, 0};
  logic [7:0] m_pdat [2] = '{8'h00, 8'h00};
  bit         m_err  [2] = '{1'b0, 1'b0};
  logic [7:0] shadow [2][4] = '{default: 8'h00};

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  vec_t tbl[$];

  task automatic chk(string nm, int k, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s dut%0d cycle %0d: got %0h expected %0h", nm, k, cyc, act, exp);
    end
  endtask

  task automatic model_clear(int k);
    m_own[k]  = -1;
    m_held[k] = 0;
    m_pref[k] = 0;
    m_pend[k] = 1'b0;
    m_err[k]  = 1'b0;
  endtask

  // Who is granted this cycle according to the arbitration rules.
  function automatic int model_grant(int k);
    int g;
    g = -1;
    if (rst) g = -1;
    else if (m_own[k] < 0) begin
      if (av && bv) g = RR ? m_pref[k] : 0;
      else if (av)  g = 0;
      else if (bv)  g = 1;
    end else if (m_own[k] == 0) g = av ? 0 : -1;
    else g = bv ? 1 : -1;
    return g;
  endfunction

  task automatic model_step(int k, int g);
    logic gwr, glk;
    logic [1:0] gsel;
    logic [7:0] gwd;
    gwr  = (g == 1) ? bwr  : awr;
    glk  = (g == 1) ? blk  : alk;
    gsel = (g == 1) ? bsel : asel;
    gwd  = (g == 1) ? bwd  : awd;
    if (rst) model_clear(k);
    else begin
      m_err[k]  = 1'b0;
      m_pend[k] = (g >= 0) && !gwr;
      if (m_pend[k]) begin
        m_pown[k] = g;
        m_pdat[k] = shadow[k][gsel];
      end
      if (g >= 0 && gwr) shadow[k][gsel] = gwd;
      if (RR && g >= 0) m_pref[k] = 1 - g;
      if (m_own[k] < 0) begin
        if (g >= 0 && glk) begin
          m_own[k]  = g;
          m_held[k] = 0;
        end
      end else if (g >= 0 && !glk) m_own[k] = -1;
      else if (m_held[k] >= lmax[k] - 1) begin
        m_own[k] = -1;
        m_err[k] = 1'b1;
      end else m_held[k]++;
    end
  endtask

  task automatic do_cycle(vec_t v, bit use_exp);
    int g;
    logic gwr;
    logic [1:0] gsel;
    logic [7:0] gwd;
    bit e_arv, e_brv;
    @(negedge clk);
    rst = v.rst[0];  av = v.av[0];  awr = v.awr[0]; asel = v.asel[1:0]; awd = v.awd[7:0]; alk = v.alk[0];
    bv  = v.bv[0];   bwr = v.bwr[0]; bsel = v.bsel[1:0]; bwd = v.bwd[7:0]; blk = v.blk[0];
    if (rst) begin
      model_clear(0);
      model_clear(1);
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      g     = model_grant(k);
      gwr   = (g == 1) ? bwr  : awr;
      gsel  = (g == 1) ? bsel : asel;
      gwd   = (g == 1) ? bwd  : awd;
      e_arv = m_pend[k] && (m_pown[k] == 0);
      e_brv = m_pend[k] && (m_pown[k] == 1);
      chk("a_req_ready", k, 32'(a_rdy[k]), 32'(g == 0));
      chk("b_req_ready", k, 32'(b_rdy[k]), 32'(g == 1));
      chk("rf_rd_en_0",  k, 32'(rden[k]),  32'((g >= 0) && !gwr));
      chk("rf_rd_sel_0", k, 32'(rsel[k]),  ((g >= 0) && !gwr) ? 32'(gsel) : 32'd0);
      chk("rf_wr_en",    k, 32'(wen[k]),   32'((g >= 0) && gwr));
      chk("rf_wr_sel",   k, 32'(wsel[k]),  ((g >= 0) && gwr) ? 32'(gsel) : 32'd0);
      chk("rf_wr_data",  k, 32'(wd[k]),    ((g >= 0) && gwr) ? 32'(gwd) : 32'd0);
      chk("a_rsp_valid", k, 32'(a_rv[k]),  32'(e_arv));
      chk("a_rsp_data",  k, 32'(a_rd[k]),  e_arv ? 32'(m_pdat[k]) : 32'd0);
      chk("b_rsp_valid", k, 32'(b_rv[k]),  32'(e_brv));
      chk("b_rsp_data",  k, 32'(b_rd[k]),  e_brv ? 32'(m_pdat[k]) : 32'd0);
      chk("lock_err",    k, 32'(lerr[k]),  32'(m_err[k]));
      model_step(k, g);
    end
    if (use_exp) begin
      chk("tbl_a_ready",  0, 32'(a_rdy[0]), v.ardy);
      chk("tbl_b_ready",  0, 32'(b_rdy[0]), v.brdy);
      chk("tbl_a_rspv",   0, 32'(a_rv[0]),  v.arv);
      chk("tbl_a_rspd",   0, 32'(a_rd[0]),  v.ard);
      chk("tbl_b_rspv",   0, 32'(b_rv[0]),  v.brv);
      chk("tbl_b_rspd",   0, 32'(b_rd[0]),  v.brd);
      chk("tbl_wr_en",    0, 32'(wen[0]),   v.wen);
      chk("tbl_wr_sel",   0, 32'(wsel[0]),  v.wsel);
      chk("tbl_wr_data",  0, 32'(wd[0]),    v.wd);
      chk("tbl_lock_err", 0, 32'(lerr[0]),  v.lerr);
    end
    cyc++;
  endtask

  initial begin
    vec_t v;
    bit ga, pa;
    //             rst av wr sel wd  lk bv wr sel wd  lk | ardy brdy arv ard brv brd wen wsel wd lerr
    tbl.push_back('{1, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0,  0, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0,  0, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    // write r2=5A then read it back
    tbl.push_back('{0, 1, 1, 2, 'h5A, 0, 0, 0, 0, 0,    0,  1, 0, 0, 0,    0, 0,    1, 2, 'h5A, 0});
    tbl.push_back('{0, 1, 0, 2, 0,    0, 0, 0, 0, 0,    0,  1, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0,  0, 0, 1, 'h5A, 0, 0,    0, 0, 0,    0});
    // preload r1=21 (A) and r3=43 (B)
    tbl.push_back('{0, 1, 1, 1, 'h21, 0, 0, 0, 0, 0,    0,  1, 0, 0, 0,    0, 0,    1, 1, 'h21, 0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 1, 1, 3, 'h43, 0,  0, 1, 0, 0,    0, 0,    1, 3, 'h43, 0});
    // contested reads for 4 cycles, then one idle cycle for the last response
    for (int i = 0; i < 5; i++) begin
      ga = (i < 4) && (RR ? (i % 2 == 0) : 1'b1);
      pa = RR ? ((i - 1) % 2 == 0) : 1'b1;
      v = '{0, 32'(i < 4), 0, 1, 0, 0, 32'(i < 4), 0, 3, 0, 0,
            32'(ga), 32'((i < 4) && !ga),
            32'((i >= 1) && pa), ((i >= 1) && pa) ? 32'h21 : 32'h0,
            32'((i >= 1) && !pa), ((i >= 1) && !pa) ? 32'h43 : 32'h0,
            0, 0, 0, 0};
      tbl.push_back(v);
    end
    // B locks r0, reads again locked, then writes r0=11 unlocked; A waits
    tbl.push_back('{0, 0, 0, 0, 0,    0, 1, 0, 0, 0,    1,  0, 1, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 1, 0, 0, 0,    0, 1, 0, 0, 0,    1,  0, 1, 0, 0,    1, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 1, 0, 0, 0,    0, 1, 1, 0, 'h11, 0,  0, 1, 0, 0,    1, 0,    1, 0, 'h11, 0});
    tbl.push_back('{0, 1, 0, 0, 0,    0, 0, 0, 0, 0,    0,  1, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0,  0, 0, 1, 'h11, 0, 0,    0, 0, 0,    0});
    // A locked read, reset mid-lock with response pending, B served after
    tbl.push_back('{0, 1, 0, 2, 0,    1, 0, 0, 0, 0,    0,  1, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{1, 1, 0, 2, 0,    1, 1, 0, 3, 0,    0,  0, 0, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 1, 0, 3, 0,    0,  0, 1, 0, 0,    0, 0,    0, 0, 0,    0});
    tbl.push_back('{0, 0, 0, 0, 0,    0, 0, 0, 0, 0,    0,  0, 0, 0, 0,    1, 'h43, 0, 0, 0,    0});
    // watchdog: A holds lock=1 reading r1; B waits on r3
    for (int i = 0; i < 12; i++) begin
      v = '{0, 32'(i < 9), 0, 1, 0, 1, 32'(i < 11), 0, 3, 0, 0,
            32'(i < 9), 32'((i == 9) || (i == 10)),
            32'((i >= 1) && (i - 1 < 9)), ((i >= 1) && (i - 1 < 9)) ? 32'h21 : 32'h0,
            32'((i - 1 == 9) || (i - 1 == 10)), ((i - 1 == 9) || (i - 1 == 10)) ? 32'h43 : 32'h0,
            0, 0, 0, 32'(i == 9)};
      tbl.push_back(v);
    end

    foreach (tbl[i]) do_cycle(tbl[i], 1'b1);

    // randomized traffic, both DUTs against the model
    for (int n = 0; n < 4000; n++) begin
      v = '{default: 0};
      v.rst  = 32'($urandom_range(0, 299) == 0);
      v.av   = 32'($urandom_range(0, 9) < 7);
      v.awr  = 32'($urandom_range(0, 9) < 4);
      v.asel = 32'($urandom_range(0, 3));
      v.awd  = 32'($urandom_range(0, 255));
      v.alk  = 32'($urandom_range(0, 9) < 3);
      v.bv   = 32'($urandom_range(0, 9) < 7);
      v.bwr  = 32'($urandom_range(0, 9) < 4);
      v.bsel = 32'($urandom_range(0, 3));
      v.bwd  = 32'($urandom_range(0, 255));
      v.blk  = 32'($urandom_range(0, 9) < 3);
      do_cycle(v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/reg_file_arbiter.md
# reg_file_arbiter

Two-requester arbiter and sequencer for the 4×8-bit register file. It shares read port 0 and the write port between the core pipeline (requester A) and the debug/monitor port (requester B). It supports locked sequences, such as atomic read-modify-write, and returns read data one cycle after grant. A lock watchdog prevents either requester from starving the other.

## Interface
- `LOCK_MAX`, default 8: maximum consecutive cycles a lock may be held before it is force-released.
- `clk`  in  1  clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous reset, active-high.
- `a_req_valid`, `b_req_valid`  in  1  request pending.
- `a_req_wr`, `b_req_wr`  in  1  1 = write, 0 = read.
- `a_req_sel`, `b_req_sel`  in  2  register index, 0..3.
- `a_req_wdata`, `b_req_wdata`  in  8  write data.
- `a_req_lock`, `b_req_lock`  in  1  keep ownership after this transaction.
- `a_req_ready`, `b_req_ready`  out  1  grant; the transaction is accepted on valid & ready.
- `a_rsp_valid`, `b_rsp_valid`  out  1  read data valid.
- `a_rsp_data`, `b_rsp_data`  out  8  read data.
- `rf_rd_en_0`  out  1  to the register file.
- `rf_rd_sel_0`  out  2  to the register file.
- `rf_wr_en`  out  1  to the register file.
- `rf_wr_sel`  out  2  to the register file.
- `rf_wr_data`  out  8  to the register file.
- `rf_rd_data_0`  in  8  registered read data from the register file, one cycle after `rf_rd_en_0`.
- `lock_err`  out  1  one-cycle pulse when the watchdog force-releases a lock.

## Operation
- FSM states: `IDLE`, `OWN_A`, `OWN_B`.
  - `IDLE`: at most one requester is granted per cycle. With both valid, the winner is chosen by the priority policy (see Configuration).
  - `OWN_X`: only X may be granted; the other requester's ready is held at 0.
- Entering a lock: a granted transaction with lock=1 moves the FSM from `IDLE` to `OWN_X`.
- Leaving a lock: in `OWN_X`, a granted X transaction with lock=0 returns the FSM to `IDLE`.
  - A transaction with lock=1 while in `OWN_X` stays in `OWN_X`.
- Lock watchdog:
  - `lock_cnt` clears on entry to `OWN_X` and increments each cycle in `OWN_X`.
  - When `lock_cnt` reaches `LOCK_MAX - 1`, the FSM returns to `IDLE` next cycle and `lock_err` pulses.
  - A transaction granted in that same final cycle still completes.
- Register-file drive (combinational from the grant):
  - Granted read: `rf_rd_en_0`=1, `rf_rd_sel_0`=sel.
  - Granted write: `rf_wr_en`=1, `rf_wr_sel`=sel, `rf_wr_data`=wdata.
  - No grant: all `rf_*` outputs are 0.
- Read response:
  - The owner of a granted read is registered into `rsp_owner` / `rsp_pend`.
  - Next cycle, that owner's `rsp_valid`=1 and its `rsp_data`=`rf_rd_data_0`.
  - The non-owner's `rsp_data` is 0.
- Ready is combinational from valid, FSM state and priority. There is no dependence of ready on ready.

## Timing
- Read latency: grant in cycle N, response in cycle N+1. Back-to-back reads give a response every cycle.
- Write latency: the write commits at the edge ending cycle N. A read granted in cycle N+1 returns the new value.
- Read-after-write of the same register in the same cycle cannot occur, because there is one grant per cycle.
- Reset values:
  - FSM=`IDLE`, `lock_cnt`=0, RR pointer=A, `rsp_pend`=0.
  - All `rsp_valid`, `rsp_data` and `lock_err` = 0.
  - ready and `rf_*` outputs are 0 while reset is high.
- Reset asserted mid-lock or with a read pending drops the lock and the response. No response is emitted after reset deasserts.
- A valid input dropped without a grant is legal; nothing is recorded.
- `LOCK_MAX`=1 means a lock is force-released after a single cycle.

## Configuration
- `REGARB_ROUND_ROBIN_EN` defined:
  - In `IDLE` with both requesters valid, the grant goes to the requester not granted most recently.
  - The pointer updates on every accepted transaction.
- `REGARB_ROUND_ROBIN_EN` undefined:
  - Fixed priority, A over B.
  - No pointer flop is present.

## Structure
- Package `regarb_pkg` holds:
  - the FSM state enum (`IDLE`/`OWN_A`/`OWN_B`);
  - the owner encoding (`OWNER_A`=0, `OWNER_B`=1);
  - constants `RF_SEL_W`=2 and `RF_DATA_W`=8.
- Sub-module `regarb_pick` contains the two-way priority/round-robin picker, including the pointer flop under the macro.
- The top level holds the FSM, the lock watchdog, the response pipeline and the register-file muxing.

## Test plan
- A writes r2=0x5A, then reads r2 → `rf_wr_en` pulse with sel=2; the read grant is followed next cycle by `a_rsp_valid`=1, `a_rsp_data`=0x5A.
- A and B both valid with reads of r1 and r3 for 4 cycles:
  - with RR: grants alternate A,B,A,B;
  - without RR: A is granted all 4 cycles and `b_req_ready`=0;
  - in both cases responses route to the correct owner.
- B locked read of r0, then an unlocked write r0=0x11 while A stays valid → A is held off for both cycles, then granted in the following cycle; the final r0 value is 0x11.
- A holds lock=1 continuously with `LOCK_MAX`=8 → `lock_err` pulses once after 8 cycles; B is granted in the next cycle if it is valid.
- Reset asserted during `OWN_A` with a read pending → immediately `a_rsp_valid`=0 and FSM=`IDLE`; after release, B is granted on its first valid cycle.
